// File: rtl/td_rf_param.sv
// Time-domain register file: stores write-pulse widths and replays them on two independent read ports.
// Optional macro TD_RF_FB_EN adds fb_i, making a write accumulate onto the stored interval instead of overwriting it.
//
// state  | meaning
// W_IDLE | waiting for a rising edge on we_i
// W_MEAS | counting we_i high cycles; commit on first low cycle
// R_IDLE | read port ready to accept a request
// R_PLAY | read port replaying a stored interval on its pulse output
module td_rf_param #(
  parameter  int DEPTH = 8,
  parameter  int TW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rstb_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          rea_i,
  input  logic          reb_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
`ifdef TD_RF_FB_EN
  input  logic          fb_i,
`endif
  output logic          a_o,
  output logic          b_o,
  output logic          wbusy_o,
  output logic          abusy_o,
  output logic          bbusy_o,
  output logic          sat_o
);

  typedef enum logic {W_IDLE, W_MEAS} w_state_t;
  typedef enum logic {R_IDLE, R_PLAY} r_state_t;

  localparam logic [TW-1:0] T_MAX = '1;

  logic [TW-1:0] mem [DEPTH];

  w_state_t      w_state;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [TW-1:0] wcnt;
  logic          ovf;
  logic [TW-1:0] commit_val;
  logic          commit_sat;

`ifdef TD_RF_FB_EN
  logic          fb_q;
  logic [TW:0]   fb_sum;

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      fb_q <= 1'b0;
    end else if (w_state == W_IDLE && we_i && !we_q) begin
      fb_q <= fb_i;
    end
  end

  assign fb_sum = {1'b0, mem[waddr_q]} + {1'b0, wcnt};

  always_comb begin
    commit_val = wcnt;
    commit_sat = ovf;
    if (fb_q) begin
      if (fb_sum[TW]) begin
        commit_val = T_MAX;
        commit_sat = 1'b1;
      end else begin
        commit_val = fb_sum[TW-1:0];
      end
    end
  end
`else
  assign commit_val = wcnt;
  assign commit_sat = ovf;
`endif

  // we_q resets high so a we_i held across reset release is not taken as a write start
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      w_state <= W_IDLE;
      we_q    <= 1'b1;
      waddr_q <= '0;
      wcnt    <= '0;
      ovf     <= 1'b0;
      wbusy_o <= 1'b0;
      sat_o   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      we_q  <= we_i;
      sat_o <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (we_i && !we_q) begin
            waddr_q <= waddr_i;
            wcnt    <= TW'(1);
            ovf     <= 1'b0;
            wbusy_o <= 1'b1;
            w_state <= W_MEAS;
          end
        end
        W_MEAS: begin
          if (we_i) begin
            if (wcnt == T_MAX) ovf  <= 1'b1;
            else               wcnt <= wcnt + TW'(1);
          end else begin
            mem[waddr_q] <= commit_val;
            sat_o        <= commit_sat;
            wcnt         <= '0;
            wbusy_o      <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  logic [1:0]    req;
  logic [AW-1:0] raddr [2];
  r_state_t      r_state [2];
  logic [TW-1:0] rcnt [2];
  logic [1:0]    play;
  logic [1:0]    rbusy;

  assign req      = {reb_i, rea_i};
  assign raddr[0] = raddr_a_i;
  assign raddr[1] = raddr_b_i;

  // Replay counter counts down to the terminal value 1, giving exactly V high cycles
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      for (int p = 0; p < 2; p++) begin
        r_state[p] <= R_IDLE;
        rcnt[p]    <= '0;
        play[p]    <= 1'b0;
        rbusy[p]   <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        case (r_state[p])
          R_IDLE: begin
            if (req[p] && mem[raddr[p]] != '0) begin
              rcnt[p]    <= mem[raddr[p]];
              play[p]    <= 1'b1;
              rbusy[p]   <= 1'b1;
              r_state[p] <= R_PLAY;
            end
          end
          R_PLAY: begin
            if (rcnt[p] == TW'(1)) begin
              rcnt[p]    <= '0;
              play[p]    <= 1'b0;
              rbusy[p]   <= 1'b0;
              r_state[p] <= R_IDLE;
            end else begin
              rcnt[p] <= rcnt[p] - TW'(1);
            end
          end
          default: r_state[p] <= R_IDLE;
        endcase
      end
    end
  end

  assign a_o     = play[0];
  assign b_o     = play[1];
  assign abusy_o = rbusy[0];
  assign bbusy_o = rbusy[1];

endmodule

// File: tb/tb_td_rf_param.sv
// Directed bench for td_rf_param; the feedback case is built only when TD_RF_FB_EN is defined.
module tb_td_rf_param;
  localparam int DEPTH = 8;
  localparam int TW    = 8;
  localparam int AW    = 3;

  logic          clk_i = 1'b0;
  logic          rstb_i = 1'b0;
  logic          we_i = 1'b0;
  logic [AW-1:0] waddr_i = '0;
  logic          rea_i = 1'b0;
  logic          reb_i = 1'b0;
  logic [AW-1:0] raddr_a_i = '0;
  logic [AW-1:0] raddr_b_i = '0;
`ifdef TD_RF_FB_EN
  logic          fb_i = 1'b0;
`endif
  logic          a_o, b_o, wbusy_o, abusy_o, bbusy_o, sat_o;

  int n_tests = 0;
  int n_fail  = 0;

  td_rf_param #(.DEPTH(DEPTH), .TW(TW)) dut (
    .clk_i     (clk_i),
    .rstb_i    (rstb_i),
    .we_i      (we_i),
    .waddr_i   (waddr_i),
    .rea_i     (rea_i),
    .reb_i     (reb_i),
    .raddr_a_i (raddr_a_i),
    .raddr_b_i (raddr_b_i),
`ifdef TD_RF_FB_EN
    .fb_i      (fb_i),
`endif
    .a_o       (a_o),
    .b_o       (b_o),
    .wbusy_o   (wbusy_o),
    .abusy_o   (abusy_o),
    .bbusy_o   (bbusy_o),
    .sat_o     (sat_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rstb_i = 1'b0;
    we_i = 1'b0; rea_i = 1'b0; reb_i = 1'b0;
    tick(); tick();
    rstb_i = 1'b1;
    tick();
  endtask

  // we_i high for n cycles into entry addr; checks busy, sat strobe at commit+1 and its clear
  task automatic wr(input int addr, input int n, input int exp_sat, input string tag);
    int sat_early;
    sat_early = 0;
    waddr_i = AW'(addr);
    we_i = 1'b1;
    tick();
    chk({tag, "_wbusy_on"}, wbusy_o, 1);
    waddr_i = AW'(~addr);
    for (int i = 1; i < n; i++) begin
      sat_early += int'(sat_o);
      tick();
    end
    sat_early += int'(sat_o);
    we_i = 1'b0;
    tick();
    chk({tag, "_wbusy_off"}, wbusy_o, 0);
    chk({tag, "_sat"}, sat_o, exp_sat);
    chk({tag, "_sat_early"}, sat_early, 0);
    tick();
    chk({tag, "_sat_clr"}, sat_o, 0);
  endtask

  // Samples len cycles; counts high cycles per port, first-high index, gaps and busy disagreement.
  // At iteration inj a one-cycle request for entry 5 is issued on port A.
  task automatic measure(input int len, input int inj, output int ca, output int cb,
                         output int err, output int fa, output int fbx);
    bit da, db;
    ca = 0; cb = 0; err = 0; fa = -1; fbx = -1; da = 0; db = 0;
    for (int i = 0; i < len; i++) begin
      if (a_o) begin
        if (da) err++;
        if (fa < 0) fa = i;
        ca++;
      end else if (ca > 0) da = 1;
      if (b_o) begin
        if (db) err++;
        if (fbx < 0) fbx = i;
        cb++;
      end else if (cb > 0) db = 1;
      if (a_o !== abusy_o) err++;
      if (b_o !== bbusy_o) err++;
      if (i == inj) begin
        rea_i = 1'b1;
        raddr_a_i = 3'd5;
      end else begin
        rea_i = 1'b0;
      end
      tick();
    end
    rea_i = 1'b0;
  endtask

  task automatic rd(input int port, input int addr, input int expv, input string tag);
    int ca, cb, err, fa, fbx;
    if (port == 0) begin rea_i = 1'b1; raddr_a_i = AW'(addr); end
    else           begin reb_i = 1'b1; raddr_b_i = AW'(addr); end
    tick();
    rea_i = 1'b0; reb_i = 1'b0;
    raddr_a_i = AW'(~addr); raddr_b_i = AW'(~addr);
    measure(expv + 4, -1, ca, cb, err, fa, fbx);
    chk({tag, "_len"}, (port == 0) ? ca : cb, expv);
    chk({tag, "_other"}, (port == 0) ? cb : ca, 0);
    chk({tag, "_busy"}, err, 0);
    if (expv > 0) chk({tag, "_start"}, (port == 0) ? fa : fbx, 0);
  endtask

  initial begin
    int ca, cb, err, fa, fbx;
    logic [9:0] pat;

    // reset state, with we_i held high through release
    rstb_i = 1'b0;
    we_i = 1'b1;
    tick(); tick();
    chk("reset_outs", {a_o, b_o, wbusy_o, abusy_o, bbusy_o, sat_o}, 0);
    rstb_i = 1'b1;
    tick(); tick(); tick();
    chk("we_held_no_write", wbusy_o, 0);
    we_i = 1'b0;
    tick();
    chk("we_low_no_write", wbusy_o, 0);
    rd(0, 0, 0, "r0_empty");

    // basic write/read
    wr(3, 5, 0, "w3");
    rd(0, 3, 5, "r3a");

    // saturation
    wr(0, 300, 1, "w0sat");
    rd(1, 0, 255, "r0b");

    // concurrent reads of different entries
    wr(2, 4, 0, "w2");
    wr(5, 7, 0, "w5");
    rea_i = 1'b1; raddr_a_i = 3'd2;
    reb_i = 1'b1; raddr_b_i = 3'd5;
    tick();
    rea_i = 1'b0; reb_i = 1'b0;
    measure(12, -1, ca, cb, err, fa, fbx);
    chk("conc_a_len", ca, 4);
    chk("conc_b_len", cb, 7);
    chk("conc_a_start", fa, 0);
    chk("conc_b_start", fbx, 0);
    chk("conc_busy", err, 0);

    // both ports on the same entry
    rea_i = 1'b1; raddr_a_i = 3'd3;
    reb_i = 1'b1; raddr_b_i = 3'd3;
    tick();
    rea_i = 1'b0; reb_i = 1'b0;
    measure(9, -1, ca, cb, err, fa, fbx);
    chk("same_a_len", ca, 5);
    chk("same_b_len", cb, 5);
    chk("same_busy", err, 0);

    // empty entry, and request during replay is ignored
    rd(0, 6, 0, "r6_empty");
    rea_i = 1'b1; raddr_a_i = 3'd2;
    tick();
    rea_i = 1'b0;
    measure(12, 1, ca, cb, err, fa, fbx);
    chk("ignore_len", ca, 4);
    chk("ignore_busy", err, 0);

    // request held high: last play cycle ignored, next cycle accepted
    pat = '0;
    rea_i = 1'b1; raddr_a_i = 3'd2;
    for (int k = 0; k < 10; k++) begin
      tick();
      pat = {pat[8:0], a_o};
    end
    rea_i = 1'b0;
    chk("b2b_pattern", pat, 10'b1111011110);
    tick(); tick(); tick(); tick(); tick(); tick();

    // read in the commit cycle sees the pre-commit value
    waddr_i = 3'd5;
    we_i = 1'b1;
    tick(); tick(); tick();
    we_i = 1'b0;
    rea_i = 1'b1; raddr_a_i = 3'd5;
    tick();
    rea_i = 1'b0;
    measure(10, -1, ca, cb, err, fa, fbx);
    chk("rw_same_old", ca, 7);
    rd(0, 5, 3, "r5_new");

    // reset mid-write
    waddr_i = 3'd4;
    we_i = 1'b1;
    tick(); tick(); tick();
    #2 rstb_i = 1'b0;
    #1 chk("rst_mid_write_busy", wbusy_o, 0);
    we_i = 1'b0;
    tick(); tick();
    rstb_i = 1'b1;
    tick();
    rd(0, 4, 0, "r4_after_rst");
    rd(0, 3, 0, "r3_cleared");

    // reset mid-replay
    wr(2, 4, 0, "w2b");
    rea_i = 1'b1; raddr_a_i = 3'd2;
    tick();
    rea_i = 1'b0;
    tick();
    chk("pre_rst_play", a_o, 1);
    #2 rstb_i = 1'b0;
    #1 chk("rst_mid_play_a", a_o, 0);
    chk("rst_mid_play_busy", abusy_o, 0);
    tick();
    rstb_i = 1'b1;
    tick();
    rd(0, 2, 0, "r2_after_rst");

`ifdef TD_RF_FB_EN
    wr(1, 10, 0, "fb_w10");
    fb_i = 1'b1;
    wr(1, 6, 0, "fb_w6_acc");
    fb_i = 1'b0;
    rd(0, 1, 16, "fb_r16");
    wr(1, 6, 0, "fb_w6_ovr");
    rd(0, 1, 6, "fb_r6");
    wr(1, 250, 0, "fb_w250");
    fb_i = 1'b1;
    wr(1, 10, 1, "fb_wsat");
    fb_i = 1'b0;
    rd(1, 1, 255, "fb_r255");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
